// File: rtl/ir_car_gen_if.sv
// ============================================================================
//  Module      : ir_car_gen_if
//  Description : Signal bundle between the IR data mux and the IR carrier
//                generator. The master drives the envelope and mode controls;
//                the slave (the carrier generator) drives LED and status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ir_car_gen_if;
    logic ir_env_i;
    logic ir_bypass_i;
    logic tx_en_i;
    logic ir_tx_o;
    logic ir_busy_o;
    logic ir_wdt_o;

    modport master (
        output ir_env_i,
        output ir_bypass_i,
        output tx_en_i,
        input  ir_tx_o,
        input  ir_busy_o,
        input  ir_wdt_o
    );

    modport slave (
        input  ir_env_i,
        input  ir_bypass_i,
        input  tx_en_i,
        output ir_tx_o,
        output ir_busy_o,
        output ir_wdt_o
    );
endinterface

`default_nettype wire

// File: rtl/ir_car_gen.sv
// ============================================================================
//  Module      : ir_car_gen
//  Description : IR transmit carrier modulator. Turns an active-high IR
//                envelope into whole periods of a fixed-frequency carrier,
//                with a pass-through mode and an LED on-time watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_car_gen #(
    parameter int CAR_DIV  = 658,   // carrier period in clk cycles
    parameter int CAR_HIGH = 219,   // high-phase length in clk cycles
    parameter int MAX_PER  = 3800   // max consecutive carrier periods
) (
    input  logic         clk,
    input  logic         rst_n,
    ir_car_gen_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] TAIL  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    localparam logic [11:0] CAR_LAST = 12'(CAR_DIV - 1);
    localparam logic [11:0] CAR_HI   = 12'(CAR_HIGH);
    localparam logic [15:0] PER_MAX  = 16'(MAX_PER);

    logic        sync1;
    logic        env_s;
    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [11:0] car_cnt;
    logic [11:0] car_nx;
    logic [15:0] per_cnt;
    logic [15:0] per_nx;
    logic        tx_r;
    logic        tx_nx;

    logic        car_wrap;
    logic [11:0] car_inc;
    logic [15:0] per_inc;

    // Free-running carrier phase and saturating period count, as seen if the
    // carrier simply keeps going this cycle.
    assign car_wrap = (car_cnt == CAR_LAST);
    assign car_inc  = car_wrap ? 12'd0 : car_cnt + 12'd1;
    assign per_inc  = !car_wrap            ? per_cnt :
                      (per_cnt == 16'hFFFF) ? per_cnt : per_cnt + 16'd1;

    // Envelope synchroniser, state and all registered datapath values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            env_s   <= 1'b0;
            state   <= IDLE;
            car_cnt <= 12'd0;
            per_cnt <= 16'd0;
            tx_r    <= 1'b0;
        end else begin
            sync1   <= bus.ir_env_i;
            env_s   <= sync1;
            state   <= state_nx;
            car_cnt <= car_nx;
            per_cnt <= per_nx;
            tx_r    <= tx_nx;
        end
    end

    // Next state: disable beats bypass beats the carrier FSM. BURST and TAIL
    // share the period-end decision; they differ only in whether the
    // envelope is still present.
    always_comb begin
        state_nx = state;
        if (!bus.tx_en_i || bus.ir_bypass_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (env_s) state_nx = BURST;
                end
                BURST, TAIL: begin
                    if (car_wrap) begin
                        // A period just completed: a burst that ended here
                        // is legal even if the watchdog limit is reached.
                        if (!env_s)                 state_nx = IDLE;
                        else if (per_inc >= PER_MAX) state_nx = FAULT;
                        else                         state_nx = BURST;
                    end else begin
                        state_nx = env_s ? BURST : TAIL;
                    end
                end
                FAULT: begin
                    if (!env_s) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Registered-output and counter updates derived from the chosen state.
    // A burst from IDLE starts at phase 0; continuing bursts and tails keep
    // the running phase so merged envelopes produce a seamless carrier.
    always_comb begin
        car_nx = 12'd0;
        per_nx = 16'd0;
        tx_nx  = 1'b0;
        if (!bus.tx_en_i) begin
            tx_nx = 1'b0;
        end else if (bus.ir_bypass_i) begin
            tx_nx = env_s;
        end else if (state_nx == BURST || state_nx == TAIL) begin
            car_nx = (state == IDLE) ? 12'd0 : car_inc;
            per_nx = (state == IDLE) ? 16'd0 : per_inc;
            tx_nx  = (car_nx < CAR_HI);
        end
    end

    assign bus.ir_tx_o   = tx_r;
    assign bus.ir_busy_o = (state != IDLE);
    assign bus.ir_wdt_o  = (state == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_ir_car_gen.sv
// ============================================================================
//  Module      : tb_ir_car_gen
//  Description : Scoreboard bench for ir_car_gen. Stimulus queues the cycle
//                and value of every expected change of {tx, busy, wdt}; a
//                monitor compares each observed change against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ir_car_gen;

    localparam int DIV  = 658;
    localparam int HIGH = 219;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   snap_req;
    event sample_ev;

    typedef struct {
        int         cyc;
        logic [2:0] vec;   // {ir_tx_o, ir_busy_o, ir_wdt_o}
    } ev_t;

    ev_t exp_q[$];

    ir_car_gen_if ifc ();

    ir_car_gen #(
        .CAR_DIV  (658),
        .CAR_HIGH (219),
        .MAX_PER  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(40 * 40000);
        $display("FAIL timeout cyc=%0d pending=%0d", cyc, exp_q.size());
        $fatal(1);
    end

    // Monitor: every output change (or an explicit snapshot) pops one entry.
    initial begin
        logic [2:0] prev;
        logic [2:0] vec;
        ev_t        e;
        prev = 3'b000;
        forever begin
            @(negedge clk or sample_ev);
            vec = {ifc.ir_tx_o, ifc.ir_busy_o, ifc.ir_wdt_o};
            if (snap_req || vec != prev) begin
                snap_req = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, vec);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec != vec) begin
                        errors++;
                        $display("FAIL event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                                 cyc, vec, e.cyc, e.vec);
                    end
                end
            end
            prev = vec;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [2:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic snapshot();
        snap_req = 1'b1;
        -> sample_ev;
        #1;
    endtask

    // Carrier starting at cycle s with nper periods, then a final state
    // change at end_c (to IDLE, or into FAULT when fault_end is set).
    task automatic carrier_burst(input int s, input int nper, input bit fault_end, input int end_c);
        push(s, 3'b110);
        for (int p = 0; p < nper; p++) begin
            push(s + p * DIV + HIGH, 3'b010);
            if (p < nper - 1) push(s + (p + 1) * DIV, 3'b110);
        end
        push(end_c, fault_end ? 3'b011 : 3'b000);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_events=%0d required=0 next_cyc=%0d",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        int c0;
        int s;
        int r;
        checks   = 0;
        errors   = 0;
        snap_req = 1'b0;
        cyc      = 0;
        rst_n    = 1'b0;
        ifc.ir_env_i    = 1'b0;
        ifc.ir_bypass_i = 1'b0;
        ifc.tx_en_i     = 1'b1;

        // Reset state
        tick(2);
        push(cyc, 3'b000);
        snapshot();
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_drained("reset");

        // Envelope of 2000 cycles rounds up to 4 full periods
        c0 = cyc;
        s  = c0 + 3;
        carrier_burst(s, 4, 1'b0, s + 4 * DIV);
        ifc.ir_env_i = 1'b1;
        tick(2000);
        ifc.ir_env_i = 1'b0;
        tick(700);
        check_drained("basic_burst");

        // 100-cycle envelope gap inside the tail merges without phase jump
        c0 = cyc;
        s  = c0 + 3;
        carrier_burst(s, 2, 1'b0, s + 2 * DIV);
        ifc.ir_env_i = 1'b1;
        tick(800);
        ifc.ir_env_i = 1'b0;
        tick(100);
        ifc.ir_env_i = 1'b1;
        tick(300);
        ifc.ir_env_i = 1'b0;
        tick(200);
        check_drained("gap_merge");

        // Watchdog: 4 periods then FAULT, cleared 2 edges after envelope drops
        c0 = cyc;
        s  = c0 + 3;
        carrier_burst(s, 4, 1'b1, s + 4 * DIV);
        push(s + 10000, 3'b000);
        ifc.ir_env_i = 1'b1;
        tick(10000);
        ifc.ir_env_i = 1'b0;
        tick(10);
        check_drained("watchdog");

        // Normal transmission after a watchdog trip
        c0 = cyc;
        s  = c0 + 3;
        carrier_burst(s, 1, 1'b0, s + DIV);
        ifc.ir_env_i = 1'b1;
        tick(300);
        ifc.ir_env_i = 1'b0;
        tick(700);
        check_drained("after_fault");

        // Bypass: square wave passes through 2 edges late, busy stays low
        ifc.ir_bypass_i = 1'b1;
        tick(5);
        c0 = cyc;
        push(c0 + 3,   3'b100);
        push(c0 + 332, 3'b000);
        push(c0 + 661, 3'b100);
        push(c0 + 990, 3'b000);
        for (int i = 0; i < 4; i++) begin
            ifc.ir_env_i = ~ifc.ir_env_i;
            tick(329);
        end
        check_drained("bypass_wave");

        // Dropping bypass mid-envelope restarts the carrier at phase 0
        c0 = cyc;
        push(c0 + 3,         3'b100);
        push(c0 + 101,       3'b110);
        push(c0 + 101 + HIGH, 3'b010);
        push(c0 + 101 + DIV, 3'b000);
        ifc.ir_env_i = 1'b1;
        tick(100);
        ifc.ir_bypass_i = 1'b0;
        tick(100);
        ifc.ir_env_i = 1'b0;
        tick(700);
        check_drained("bypass_exit");

        // tx_en drop at car_cnt=100 truncates; re-enable gives a fresh burst
        c0 = cyc;
        s  = c0 + 3;
        push(s,              3'b110);
        push(s + 101,        3'b000);
        push(s + 151,        3'b110);
        push(s + 151 + HIGH, 3'b010);
        push(s + 151 + DIV,  3'b000);
        ifc.ir_env_i = 1'b1;
        tick(103);
        ifc.tx_en_i = 1'b0;
        tick(50);
        ifc.tx_en_i = 1'b1;
        tick(347);
        ifc.ir_env_i = 1'b0;
        tick(400);
        check_drained("tx_en_drop");

        // Asynchronous reset mid high phase, then restart after release
        c0 = cyc;
        s  = c0 + 3;
        push(s, 3'b110);
        ifc.ir_env_i = 1'b1;
        tick(53);
        rst_n = 1'b0;
        #1;
        push(cyc, 3'b000);
        snapshot();
        tick(5);
        rst_n = 1'b1;
        r = cyc;
        carrier_burst(r + 3, 1, 1'b0, r + 3 + DIV);
        tick(300);
        ifc.ir_env_i = 1'b0;
        tick(500);
        check_drained("async_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ir_car_gen.md
Name: ir_car_gen

Overview:
- IR transmit-side carrier modulator. Converts a demodulated IR envelope (active-high burst) into an LED drive signal carrying a fixed-frequency carrier.
- Sits between the IR data mux and the IR LED driver pin, mirroring the receive-side carrier detection.
- Produces whole carrier periods only, so no runt pulses occur at burst ends.
- Includes a pass-through mode for sources that are already carrier-modulated, and an on-time watchdog that protects the LED.

Parameters:
- CAR_DIV, 658: carrier period in clk cycles (25 MHz / 38 kHz); legal range 4..4095.
- CAR_HIGH, 219: carrier high-phase length in clk cycles (1/3 duty); legal range 1..CAR_DIV-1.
- MAX_PER, 3800: maximum consecutive carrier periods per burst (about 100 ms); legal range 1..65535.

Ports:
- clk  input  1  system clock, 25 MHz (40 ns period)
- rst_n  input  1  reset, asynchronous, active-low
- ir_env_i  input  1  IR envelope, asynchronous to clk; 1 = emit carrier
- ir_bypass_i  input  1  1 = pass the synchronised envelope straight to the output with no modulation; quasi-static
- tx_en_i  input  1  transmit enable; 0 forces the output off; quasi-static
- ir_tx_o  output  1  LED drive, registered
- ir_busy_o  output  1  1 while the FSM is not in IDLE
- ir_wdt_o  output  1  1 while the FSM is in FAULT (watchdog tripped)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All flops use an async clear on rst_n.
- Reset values: ir_tx_o=0, ir_busy_o=0, ir_wdt_o=0, state=IDLE, car_cnt=0, per_cnt=0, sync flops=0.
- Synchroniser: ir_env_i passes through two flops. The second flop is env_s.
- Latency: if ir_env_i is sampled high at edge E, ir_tx_o goes high after edge E+2. The same latency applies to bypass mode.
- car_cnt is 12 bits and counts 0..CAR_DIV-1, then wraps to 0. per_cnt is 16 bits and saturates.
- Priority at each edge: tx_en_i==0, then ir_bypass_i==1, then the FSM.
- tx_en_i==0:
  - Next state IDLE; ir_tx_o<=0; counters cleared.
  - This is immediate: a running period is truncated.
- ir_bypass_i==1:
  - State forced to IDLE; ir_tx_o<=env_s; counters cleared.
  - The watchdog is not applied.
  - Dropping bypass while env_s=1 starts a fresh BURST at the next edge.
- States:
  - IDLE: ir_tx_o<=0. If env_s=1: go to BURST, car_cnt<=0, per_cnt<=0, ir_tx_o<=1.
  - BURST:
    - car_cnt advances each cycle.
    - ir_tx_o<=1 when the new car_cnt < CAR_HIGH, else 0. The result is CAR_HIGH cycles high and CAR_DIV-CAR_HIGH cycles low per period.
    - On wrap (car_cnt==CAR_DIV-1), per_cnt increments.
    - If the incremented per_cnt equals MAX_PER while env_s=1: go to FAULT, ir_tx_o<=0.
    - If env_s=0: go to TAIL. Carrier continues without a phase change.
  - TAIL:
    - Carrier continues until the current period completes.
    - At car_cnt==CAR_DIV-1: go to IDLE, ir_tx_o<=0.
    - If env_s returns to 1 before then: go back to BURST with no phase reset and per_cnt kept, giving a continuous carrier.
  - FAULT: ir_tx_o<=0, ir_wdt_o=1. Leave to IDLE only when env_s=0. A new burst then requires env_s to rise again.
- Simultaneous events:
  - If the wrap reaching MAX_PER coincides with env_s=0, go to IDLE. No FAULT, because the burst ended legally.
  - If a TAIL completion coincides with env_s=1, go back to BURST, car_cnt=0.
- Envelope gaps: an envelope low pulse shorter than the remaining tail merges the bursts.
- Output characteristics:
  - ir_tx_o never produces a high phase shorter than CAR_HIGH, except on a tx_en_i truncation.
  - Every burst ends with a full low phase.
- ir_busy_o and ir_wdt_o are decoded from the registered state, so they are glitch-free.
- Reset mid-burst: all outputs are 0 asynchronously, and no tail is emitted.

Test Plan:
- Defaults, tx_en=1, bypass=0. Drive ir_env_i high for 2000 cycles, then low. Expect:
  - ir_tx_o rising 2 edges after the sampling edge.
  - Repeating 219 high / 439 low.
  - Rounding to 4 full periods (2632 cycles from first rise), ending low.
  - ir_busy_o high for the whole span.
- Envelope low for 100 cycles mid-period (during TAIL), then high again. Expect:
  - The carrier is uninterrupted, with no phase jump (period remains 658).
  - ir_busy_o stays 1.
- MAX_PER=4, envelope held high for 10000 cycles. Expect:
  - Exactly 4 periods, then ir_tx_o=0 and ir_wdt_o=1.
  - After the envelope falls, ir_wdt_o clears 2 edges later.
  - A new envelope pulse transmits normally.
- ir_bypass_i=1. Drive ir_env_i with a 38 kHz square wave. Expect ir_tx_o to be that wave delayed by 2 edges, with ir_busy_o=0. Toggle bypass off mid-burst and expect an internal carrier restart from phase 0.
- Drop tx_en_i at car_cnt=100 inside BURST. Expect ir_tx_o=0 on the next edge and state IDLE. With env still high, re-raise tx_en_i and expect a fresh burst.
- Assert rst_n=0 mid-high-phase. Expect ir_tx_o, ir_busy_o and ir_wdt_o all 0 immediately, without waiting for an edge. After release with the envelope high, expect a burst starting about 3 edges later.
